// File: rtl/bconv_pkg.sv
// Shared types and default geometry for the binary-convolution window sequencer.
package bconv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // $clog2 that never yields a zero-width vector
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_INPUT_H  = 28;
  localparam int unsigned DEF_INPUT_W  = 28;
  localparam int unsigned DEF_K_H      = 3;
  localparam int unsigned DEF_K_W      = 3;
  localparam int unsigned DEF_OUTPUT_H = DEF_INPUT_H - DEF_K_H + 1;
  localparam int unsigned DEF_OUTPUT_W = DEF_INPUT_W - DEF_K_W + 1;
  localparam int unsigned PCW          = $clog2(DEF_K_H * DEF_K_W + 1);
  localparam int unsigned ROW_W        = clog2_min1(DEF_OUTPUT_H);
  localparam int unsigned COL_W        = clog2_min1(DEF_OUTPUT_W);

endpackage

// File: rtl/bconv_window_sequencer_if.sv
// Window-issue, result-return and output-write signals between sequencer and datapath/storage.
interface bconv_window_sequencer_if
  import bconv_pkg::*;
#(
  parameter int unsigned ROW_W = bconv_pkg::ROW_W,
  parameter int unsigned COL_W = bconv_pkg::COL_W,
  parameter int unsigned PCW   = bconv_pkg::PCW
);
  logic             win_valid;
  logic             win_ready;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic             res_valid;
  logic [PCW-1:0]   res_popcount;
  logic             out_we;
  logic [ROW_W-1:0] out_row;
  logic [COL_W-1:0] out_col;
  logic             out_bit;

  modport master (
    output win_valid, win_row, win_col, out_we, out_row, out_col, out_bit,
    input  win_ready, res_valid, res_popcount
  );

  modport slave (
    input  win_valid, win_row, win_col, out_we, out_row, out_col, out_bit,
    output win_ready, res_valid, res_popcount
  );
endinterface

// File: rtl/bconv_raster_counter.sv
// Row/col raster counter with clear, enable and a last-position flag.
module bconv_raster_counter #(
  parameter int unsigned ROWS  = 26,
  parameter int unsigned COLS  = 26,
  parameter int unsigned ROW_W = 5,
  parameter int unsigned COL_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [ROW_W-1:0] o_row,
  output logic [COL_W-1:0] o_col,
  output logic             o_last_c
);
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic             w_col_wrap;

  assign w_col_wrap = (r_col == COL_W'(COLS - 1));
  assign o_last_c   = w_col_wrap && (r_row == ROW_W'(ROWS - 1));
  assign o_row      = r_row;
  assign o_col      = r_col;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_en) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= o_last_c ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end
endmodule

// File: rtl/bconv_window_sequencer.sv
// Walks every KxK window in raster order, issues it to the XNOR/popcount datapath and
// binarizes the in-order results into the output map.
module bconv_window_sequencer
  import bconv_pkg::*;
#(
  parameter int unsigned INPUT_H         = DEF_INPUT_H,
  parameter int unsigned INPUT_W         = DEF_INPUT_W,
  parameter int unsigned K_H             = DEF_K_H,
  parameter int unsigned K_W             = DEF_K_W,
  parameter int unsigned OUTPUT_H        = INPUT_H - K_H + 1,
  parameter int unsigned OUTPUT_W        = INPUT_W - K_W + 1,
  parameter int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned TH_W           = $clog2(K_H * K_W + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [TH_W-1:0] threshold,
  output logic            busy,
  output logic            done,
  bconv_window_sequencer_if.master bus
);
  localparam int unsigned R_W = clog2_min1(OUTPUT_H);
  localparam int unsigned C_W = clog2_min1(OUTPUT_W);
  localparam int unsigned OCW = clog2_min1(MAX_OUTSTANDING + 1);

  state_t          r_state;
  logic [TH_W-1:0] r_thr;
  logic [OCW-1:0]  r_outstanding;
  logic            r_win_valid;
  logic            r_out_we;
  logic            r_out_bit;
  logic            r_out_last;
  logic [R_W-1:0]  r_out_row;
  logic [C_W-1:0]  r_out_col;
  logic            r_busy;
  logic            r_done;

  logic            w_accept_start;
  logic            w_hs;
  logic            w_res_ok;
  logic            w_room;
  logic [OCW-1:0]  w_outstanding_nxt;
  logic [R_W-1:0]  w_iss_row;
  logic [C_W-1:0]  w_iss_col;
  logic            w_iss_last;
  logic [R_W-1:0]  w_wr_row;
  logic [C_W-1:0]  w_wr_col;
  logic            w_wr_last;

  assign w_accept_start    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_hs              = r_win_valid && bus.win_ready;
  // A result with nothing outstanding is a protocol error and is dropped
  assign w_res_ok          = bus.res_valid && (r_outstanding != '0);
  assign w_outstanding_nxt = r_outstanding + OCW'(w_hs) - OCW'(w_res_ok);
  assign w_room            = (w_outstanding_nxt < OCW'(MAX_OUTSTANDING));

  bconv_raster_counter #(.ROWS(OUTPUT_H), .COLS(OUTPUT_W), .ROW_W(R_W), .COL_W(C_W)) u_issue_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_accept_start),
    .i_en     (w_hs),
    .o_row    (w_iss_row),
    .o_col    (w_iss_col),
    .o_last_c (w_iss_last)
  );

  bconv_raster_counter #(.ROWS(OUTPUT_H), .COLS(OUTPUT_W), .ROW_W(R_W), .COL_W(C_W)) u_write_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clr    (w_accept_start),
    .i_en     (w_res_ok),
    .o_row    (w_wr_row),
    .o_col    (w_wr_col),
    .o_last_c (w_wr_last)
  );

  // Pass control plus all registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_thr         <= '0;
      r_outstanding <= '0;
      r_win_valid   <= 1'b0;
      r_out_we      <= 1'b0;
      r_out_bit     <= 1'b0;
      r_out_last    <= 1'b0;
      r_out_row     <= '0;
      r_out_col     <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_out_we      <= w_res_ok;
      r_out_bit     <= w_res_ok && (bus.res_popcount >= r_thr);
      r_out_last    <= w_res_ok && w_wr_last;
      r_outstanding <= w_outstanding_nxt;
      if (w_res_ok) begin
        r_out_row <= w_wr_row;
        r_out_col <= w_wr_col;
      end
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state       <= ST_ISSUE;
            r_thr         <= threshold;
            r_outstanding <= '0;
            r_win_valid   <= 1'b1;
            r_busy        <= 1'b1;
            r_done        <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (w_hs && w_iss_last) begin
            r_state     <= ST_DRAIN;
            r_win_valid <= 1'b0;
          end else begin
            r_win_valid <= w_room;
          end
        end
        ST_DRAIN: begin
          if (r_out_we && r_out_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.win_valid = r_win_valid;
  assign bus.win_row   = w_iss_row;
  assign bus.win_col   = w_iss_col;
  assign bus.out_we    = r_out_we;
  assign bus.out_row   = r_out_row;
  assign bus.out_col   = r_out_col;
  assign bus.out_bit   = r_out_bit;
  assign busy          = r_busy;
  assign done          = r_done;

  a_no_orphan_result: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.res_valid && (r_outstanding == '0)));

endmodule
